udp_send: RTL and testbench

//  Transmit-side framer, the mirror of the receive path: accepts one UDP payload stream per request and emits a

---
 rtl/udp_pkg.sv | 39 +++
 rtl/udp_send_if.sv | 39 +++
 rtl/udp_ip_checksum.sv | 44 ++++
 rtl/udp_send.sv | 213 +++++++++++++++++++++
 tb/tb_udp_send.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkg.sv
// udp_pkg: constants, transmit state encoding and field record shared by the
// UDP transmit and receive paths.
package udp_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;

  localparam int ETH_HDR_LEN   = 14;
  localparam int IP_HDR_LEN    = 20;
  localparam int UDP_HDR_LEN   = 8;
  localparam int TX_HDR_LEN    = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int MIN_FRAME_LEN = 60;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_CSUM,
    TX_HDR,
    TX_PAYLOAD,
    TX_PAD,
    TX_DROP
  } tx_state_t;

  // Everything captured from the request at accept time.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } tx_fields_t;

  // Byte 'pos' of a right-aligned field, counted from the least significant end.
  function automatic logic [7:0] be_byte(input logic [63:0] v, input logic [2:0] pos);
    return v[8*pos +: 8];
  endfunction

endpackage

// File: rtl/udp_send_if.sv
// udp_send_if: request, payload stream and MAC-side stream of the UDP framer.
// master = client/MAC side, slave = the framer.
interface udp_send_if;
  logic [47:0] local_mac_addr;
  logic [31:0] local_ip_addr;
  logic [47:0] remote_mac_addr_in;
  logic [31:0] remote_ip_addr_in;
  logic [15:0] local_port_in;
  logic [15:0] remote_port_in;
  logic [15:0] udp_length_in;
  logic        tx_req_in;
  logic        tx_ack_out;
  logic        tx_err_out;
  logic [7:0]  udpdata_tdata_in;
  logic        udpdata_tvalid_in;
  logic        udpdata_tlast_in;
  logic        udpdata_tready_out;
  logic [7:0]  axis_tdata_out;
  logic        axis_tvalid_out;
  logic        axis_tlast_out;
  logic        axis_tready_in;
  logic        busy_out;

  modport master (
    output local_mac_addr, local_ip_addr, remote_mac_addr_in, remote_ip_addr_in,
           local_port_in, remote_port_in, udp_length_in, tx_req_in,
           udpdata_tdata_in, udpdata_tvalid_in, udpdata_tlast_in, axis_tready_in,
    input  tx_ack_out, tx_err_out, udpdata_tready_out,
           axis_tdata_out, axis_tvalid_out, axis_tlast_out, busy_out
  );

  modport slave (
    input  local_mac_addr, local_ip_addr, remote_mac_addr_in, remote_ip_addr_in,
           local_port_in, remote_port_in, udp_length_in, tx_req_in,
           udpdata_tdata_in, udpdata_tvalid_in, udpdata_tlast_in, axis_tready_in,
    output tx_ack_out, tx_err_out, udpdata_tready_out,
           axis_tdata_out, axis_tvalid_out, axis_tlast_out, busy_out
  );
endinterface

// File: rtl/udp_ip_checksum.sv
// udp_ip_checksum: IPv4 header checksum over nine 16-bit words.
// Cycle with start: registers the 32-bit sum. Next cycle (done=1): folds the
// carries twice and stores the inverted result, readable from the cycle after.
module udp_ip_checksum (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0][15:0] words,
  output logic             done,
  output logic [15:0]      csum
);

  logic [31:0] sum_d;
  logic [31:0] sum_q;
  logic        pend_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Plain 32-bit sum of all header words; nine 16-bit words cannot overflow it.
  always_comb begin
    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + {16'd0, words[i]};
  end

  assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
  assign done  = pend_q;

  // Sum register, fold stage flag and final checksum.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!reset) begin
      sum_q  <= '0;
      pend_q <= 1'b0;
      csum   <= '0;
    end else begin
      pend_q <= start;
      if (start)  sum_q <= sum_d;
      if (pend_q) csum  <= ~fold2;
    end
  end

endmodule

// File: rtl/udp_send.sv
// udp_send: Ethernet II / IPv4 / UDP transmit framer (no FCS), 8-bit stream out.
// Build option: define UDP_SEND_PAD_EN to pad frames shorter than 60 bytes with
// zero bytes; without it the frame ends on the last payload (or header) byte.
module udp_send
  import udp_pkg::*;
#(
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          MAX_PAYLOAD = 1472,
  parameter logic [15:0] ID_INIT     = 16'h0000
) (
  input logic       clk,
  input logic       reset,
  udp_send_if.slave s
);

  tx_state_t  state_q, state_d;
  tx_fields_t fld_q;
  logic [15:0] ip_id_q;
  logic [5:0]  hdr_idx_q;
  logic [15:0] pay_cnt_q;
  logic [5:0]  pad_idx_q;
  logic        short_q, drop_pend_q, rej_q, ack_q, err_q;

  logic        len_ok, req_ok, req_bad;
  logic        hdr_last, pay_last, pad_last, pad_needed;
  logic        out_beat, in_beat;
  logic [15:0] total_len, udp_len, csum;
  logic        csum_start, csum_done;
  logic [8:0][15:0] csum_words;
  logic [7:0]  hdr_byte;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tready_up, busy;

  assign len_ok   = s.udp_length_in <= 16'(MAX_PAYLOAD);
  assign req_ok   = (state_q == TX_IDLE) && s.tx_req_in && len_ok;
  assign req_bad  = (state_q == TX_IDLE) && s.tx_req_in && !len_ok;

  assign total_len = 16'(IP_HDR_LEN + UDP_HDR_LEN) + fld_q.length;
  assign udp_len   = 16'(UDP_HDR_LEN) + fld_q.length;

  assign hdr_last = hdr_idx_q == 6'(TX_HDR_LEN - 1);
  assign pay_last = pay_cnt_q == fld_q.length - 16'd1;
  assign pad_last = pad_idx_q == 6'(MIN_FRAME_LEN - 1);
`ifdef UDP_SEND_PAD_EN
  assign pad_needed = fld_q.length < 16'(MIN_FRAME_LEN - TX_HDR_LEN);
`else
  assign pad_needed = 1'b0;
`endif

  assign out_beat = tvalid && s.axis_tready_in;
  assign in_beat  = s.udpdata_tvalid_in && tready_up;

  // Header words with the checksum field taken as zero (0x4500: version 4, IHL 5).
  assign csum_words = {16'h4500, total_len, ip_id_q, 16'h4000, {TTL, IP_PROTO_UDP},
                       fld_q.src_ip[31:16], fld_q.src_ip[15:0],
                       fld_q.dst_ip[31:16], fld_q.dst_ip[15:0]};
  assign csum_start = (state_q == TX_CSUM) && !csum_done;

  udp_ip_checksum u_csum (
    .clk   (clk),
    .reset (reset),
    .start (csum_start),
    .words (csum_words),
    .done  (csum_done),
    .csum  (csum)
  );

  // Header byte selected by the beat counter from the latched fields.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx_q) inside
      [6'd0:6'd5]:   hdr_byte = be_byte({16'd0, fld_q.dst_mac}, 3'(6'd5 - hdr_idx_q));
      [6'd6:6'd11]:  hdr_byte = be_byte({16'd0, fld_q.src_mac}, 3'(6'd11 - hdr_idx_q));
      6'd12:         hdr_byte = ETH_TYPE_IPV4[15:8];
      6'd13:         hdr_byte = ETH_TYPE_IPV4[7:0];
      6'd14:         hdr_byte = 8'h45;
      6'd16:         hdr_byte = total_len[15:8];
      6'd17:         hdr_byte = total_len[7:0];
      6'd18:         hdr_byte = ip_id_q[15:8];
      6'd19:         hdr_byte = ip_id_q[7:0];
      6'd20:         hdr_byte = 8'h40;
      6'd22:         hdr_byte = TTL;
      6'd23:         hdr_byte = IP_PROTO_UDP;
      6'd24:         hdr_byte = csum[15:8];
      6'd25:         hdr_byte = csum[7:0];
      [6'd26:6'd29]: hdr_byte = be_byte({32'd0, fld_q.src_ip}, 3'(6'd29 - hdr_idx_q));
      [6'd30:6'd33]: hdr_byte = be_byte({32'd0, fld_q.dst_ip}, 3'(6'd33 - hdr_idx_q));
      6'd34:         hdr_byte = fld_q.src_port[15:8];
      6'd35:         hdr_byte = fld_q.src_port[7:0];
      6'd36:         hdr_byte = fld_q.dst_port[15:8];
      6'd37:         hdr_byte = fld_q.dst_port[7:0];
      6'd38:         hdr_byte = udp_len[15:8];
      6'd39:         hdr_byte = udp_len[7:0];
      default:       hdr_byte = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; transitions out of streaming states happen on beats.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:    if (req_ok) state_d = TX_CSUM;
      TX_CSUM:    if (csum_done) state_d = TX_HDR;
      TX_HDR:
        if (out_beat && hdr_last) begin
          if (fld_q.length != 16'd0) state_d = TX_PAYLOAD;
          else if (pad_needed)       state_d = TX_PAD;
          else                       state_d = TX_IDLE;
        end
      TX_PAYLOAD:
        if (out_beat && pay_last) begin
          if (pad_needed)                              state_d = TX_PAD;
          else if (!short_q && !s.udpdata_tlast_in)    state_d = TX_DROP;
          else                                         state_d = TX_IDLE;
        end
      TX_PAD:
        if (out_beat && pad_last) state_d = drop_pend_q ? TX_DROP : TX_IDLE;
      TX_DROP:    if (in_beat && s.udpdata_tlast_in) state_d = TX_IDLE;
      default:    state_d = TX_IDLE;
    endcase
  end

  // FSM outputs: stream muxing and the payload ready pass-through.
  always_comb begin
    tvalid    = 1'b0;
    tdata     = 8'h00;
    tlast     = 1'b0;
    tready_up = 1'b0;
    busy      = state_q != TX_IDLE;
    case (state_q)
      TX_HDR: begin
        tvalid = 1'b1;
        tdata  = hdr_byte;
        tlast  = hdr_last && (fld_q.length == 16'd0) && !pad_needed;
      end
      TX_PAYLOAD: begin
        // After a short input the remaining bytes are zero fill; upstream is left alone.
        tvalid    = short_q ? 1'b1 : s.udpdata_tvalid_in;
        tdata     = short_q ? 8'h00 : s.udpdata_tdata_in;
        tready_up = short_q ? 1'b0 : s.axis_tready_in;
        tlast     = pay_last && !pad_needed;
      end
      TX_PAD: begin
        tvalid = 1'b1;
        tlast  = pad_last;
      end
      TX_DROP:  tready_up = 1'b1;
      default: ;
    endcase
  end

  // Request capture, beat counters, error flags and the IP identification counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fld_q       <= '0;
      ip_id_q     <= ID_INIT;
      hdr_idx_q   <= '0;
      pay_cnt_q   <= '0;
      pad_idx_q   <= '0;
      short_q     <= 1'b0;
      drop_pend_q <= 1'b0;
      rej_q       <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      // A rejected request is reported once, however long it stays asserted.
      rej_q <= req_bad;
      if (req_bad && !rej_q) err_q <= 1'b1;
      if (req_ok) begin
        fld_q       <= '{dst_mac:  s.remote_mac_addr_in, src_mac:  s.local_mac_addr,
                         dst_ip:   s.remote_ip_addr_in,  src_ip:   s.local_ip_addr,
                         src_port: s.local_port_in,      dst_port: s.remote_port_in,
                         length:   s.udp_length_in};
        ack_q       <= 1'b1;
        hdr_idx_q   <= '0;
        pay_cnt_q   <= '0;
        short_q     <= 1'b0;
        drop_pend_q <= 1'b0;
      end
      if (state_q == TX_HDR && out_beat) hdr_idx_q <= hdr_idx_q + 6'd1;
      if (state_q == TX_PAYLOAD && out_beat) begin
        pay_cnt_q <= pay_cnt_q + 16'd1;
        if (!short_q && s.udpdata_tlast_in && !pay_last) begin
          short_q <= 1'b1;
          err_q   <= 1'b1;
        end
        if (!short_q && !s.udpdata_tlast_in && pay_last) drop_pend_q <= 1'b1;
      end
      if (state_d == TX_PAD && state_q != TX_PAD)
        pad_idx_q <= 6'(TX_HDR_LEN) + fld_q.length[5:0];
      else if (state_q == TX_PAD && out_beat)
        pad_idx_q <= pad_idx_q + 6'd1;
      if (out_beat && tlast) ip_id_q <= ip_id_q + 16'd1;
    end
  end

  assign s.tx_ack_out         = ack_q;
  assign s.tx_err_out         = err_q;
  assign s.udpdata_tready_out = tready_up;
  assign s.axis_tdata_out     = tdata;
  assign s.axis_tvalid_out    = tvalid;
  assign s.axis_tlast_out     = tlast;
  assign s.busy_out           = busy;

endmodule

// File: tb/tb_udp_send.sv
// tb_udp_send: table-driven frames with random fields/payload/stalls compared
// against a byte-level frame model, plus reject and mid-frame reset sequences.
module tb_udp_send;
  import udp_pkg::*;

`ifdef UDP_SEND_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam logic [15:0] ID_INIT = 16'h0000;

  typedef logic [7:0] byteq_t[$];

  typedef struct {
    int len;
    int n_in;
    bit stall;
    int exp_len;
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udp_send_if u_if ();

  udp_send dut (
    .clk   (clk),
    .reset (reset),
    .s     (u_if)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] model_id;
  byteq_t rx;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id,
                                          input logic [31:0] sip, input logic [31:0] dip);
    int unsigned acc;
    acc = 32'h4500 + tl + id + 32'h4000 + {16'd0, 8'd64, 8'h11}
        + sip[31:16] + sip[15:0] + dip[31:16] + dip[15:0];
    while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
    return ~acc[15:0];
  endfunction

  // Expected on-wire frame built straight from the field layout.
  task automatic model_frame(input logic [47:0] dmac, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] sp, input logic [15:0] dp,
                             input logic [15:0] id, input int len, input byteq_t pay,
                             output byteq_t q);
    logic [335:0] hdr;
    logic [15:0] tl, ul;
    tl  = 16'(28 + len);
    ul  = 16'(8 + len);
    hdr = {dmac, smac, 16'h0800, 8'h45, 8'h00, tl, id, 16'h4000, 8'd64, 8'h11,
           ip_csum(tl, id, sip, dip), sip, dip, sp, dp, ul, 16'h0000};
    q = {};
    for (int i = 0; i < 42; i++) q.push_back(hdr[335 - 8*i -: 8]);
    for (int i = 0; i < len; i++) q.push_back(i < pay.size() ? pay[i] : 8'h00);
    if (PAD_EN) while (q.size() < 60) q.push_back(8'h00);
  endtask

  // One request/frame with payload driver, collector and per-frame checks.
  task automatic run_frame(input string tag, input int len, input int n_in, input bit stall,
                           input int exp_len, input bit exp_err, input bit fixed);
    byteq_t pay, exp_q;
    int pi, cyc, acks, errs, tlasts, tlast_pos, ack_cyc, first_cyc, stab_bad, mism;
    bit fin, in_take, prev_stall;
    logic [7:0] prev_data;
    if (fixed) begin
      u_if.local_mac_addr     = 48'h02_00_00_00_00_01;
      u_if.remote_mac_addr_in = 48'h02_00_00_00_00_02;
      u_if.local_ip_addr      = 32'hC0A8_010A;
      u_if.remote_ip_addr_in  = 32'hC0A8_0114;
      u_if.local_port_in      = 16'd1234;
      u_if.remote_port_in     = 16'd5678;
      pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    end else begin
      u_if.local_mac_addr     = {16'($urandom), $urandom};
      u_if.remote_mac_addr_in = {16'($urandom), $urandom};
      u_if.local_ip_addr      = $urandom;
      u_if.remote_ip_addr_in  = $urandom;
      u_if.local_port_in      = 16'($urandom);
      u_if.remote_port_in     = 16'($urandom);
      pay = {};
      for (int i = 0; i < n_in; i++) pay.push_back(8'($urandom));
    end
    model_frame(u_if.remote_mac_addr_in, u_if.local_mac_addr, u_if.local_ip_addr,
                u_if.remote_ip_addr_in, u_if.local_port_in, u_if.remote_port_in,
                model_id, len, pay, exp_q);
    u_if.udp_length_in     = 16'(len);
    u_if.tx_req_in         = 1'b1;
    u_if.axis_tready_in    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    pi = 0;
    u_if.udpdata_tvalid_in = n_in > 0;
    u_if.udpdata_tdata_in  = n_in > 0 ? pay[0] : 8'h00;
    u_if.udpdata_tlast_in  = n_in == 1;
    acks = 0; errs = 0; tlasts = 0; tlast_pos = -1; ack_cyc = -100; first_cyc = -1;
    stab_bad = 0; fin = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    rx = {};
    for (cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (tlasts > 0 && !u_if.busy_out && pi >= n_in) begin
        fin = 1'b1;
        break;
      end
      if (u_if.tx_ack_out) begin acks++; ack_cyc = cyc; end
      if (u_if.tx_err_out) errs++;
      if (prev_stall && (!u_if.axis_tvalid_out || u_if.axis_tdata_out !== prev_data)) stab_bad++;
      if (u_if.axis_tvalid_out) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (u_if.axis_tready_in) begin
          rx.push_back(u_if.axis_tdata_out);
          if (u_if.axis_tlast_out) begin tlasts++; tlast_pos = rx.size(); end
        end
      end
      prev_stall = u_if.axis_tvalid_out && !u_if.axis_tready_in;
      prev_data  = u_if.axis_tdata_out;
      in_take    = u_if.udpdata_tvalid_in && u_if.udpdata_tready_out;
      @(posedge clk);
      #1;
      if (acks > 0) u_if.tx_req_in = 1'b0;
      if (in_take) pi++;
      u_if.udpdata_tvalid_in = pi < n_in;
      u_if.udpdata_tdata_in  = pi < n_in ? pay[pi] : 8'h00;
      u_if.udpdata_tlast_in  = pi == n_in - 1;
      u_if.axis_tready_in    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    u_if.tx_req_in = 1'b0;
    check({tag, " completed"}, fin, 1'b1);
    check({tag, " ack count"}, acks, 1);
    check({tag, " err count"}, errs, exp_err);
    check({tag, " frame length"}, rx.size(), exp_len);
    mism = 0;
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) if (rx[i] !== exp_q[i]) mism++;
    check({tag, " byte mismatches"}, mism, 0);
    check({tag, " tlast count"}, tlasts, 1);
    check({tag, " tlast position"}, tlast_pos, exp_len);
    check({tag, " first byte latency"}, first_cyc - ack_cyc, 2);
    check({tag, " stall stability"}, stab_bad, 0);
    check({tag, " payload consumed"}, pi, n_in);
    model_id = model_id + 16'd1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    int beats, errs, acks, valids;
    bit reached;
    vecs[0] = '{4,    4,    1'b0, PAD_EN ? 60 : 46,   1'b0};
    vecs[1] = '{100,  100,  1'b0, 142,                1'b0};
    vecs[2] = '{100,  100,  1'b1, 142,                1'b0};
    vecs[3] = '{8,    5,    1'b0, PAD_EN ? 60 : 50,   1'b1};
    vecs[4] = '{4,    7,    1'b0, PAD_EN ? 60 : 46,   1'b0};
    vecs[5] = '{0,    0,    1'b0, PAD_EN ? 60 : 42,   1'b0};
    vecs[6] = '{17,   17,   1'b1, PAD_EN ? 60 : 59,   1'b0};
    vecs[7] = '{18,   18,   1'b0, 60,                 1'b0};
    vecs[8] = '{30,   12,   1'b1, 72,                 1'b1};
    vecs[9] = '{1472, 1472, 1'b0, 1514,               1'b0};

    u_if.local_mac_addr = '0;  u_if.local_ip_addr = '0;
    u_if.remote_mac_addr_in = '0; u_if.remote_ip_addr_in = '0;
    u_if.local_port_in = '0; u_if.remote_port_in = '0; u_if.udp_length_in = '0;
    u_if.tx_req_in = 1'b0; u_if.udpdata_tdata_in = '0; u_if.udpdata_tvalid_in = 1'b0;
    u_if.udpdata_tlast_in = 1'b0; u_if.axis_tready_in = 1'b1;
    model_id = ID_INIT;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tvalid", u_if.axis_tvalid_out, 1'b0);
    check("reset tlast", u_if.axis_tlast_out, 1'b0);
    check("reset ack", u_if.tx_ack_out, 1'b0);
    check("reset err", u_if.tx_err_out, 1'b0);
    check("reset busy", u_if.busy_out, 1'b0);
    check("reset tready_out", u_if.udpdata_tready_out, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Worked example: fixed addresses, DE AD BE EF, id starting at reset value.
    run_frame("example", 4, 4, 1'b0, PAD_EN ? 60 : 46, 1'b0, 1'b1);
    if (rx.size() >= 42) begin
      check("example total_len", {rx[16], rx[17]}, 16'h0020);
      check("example ip_id", {rx[18], rx[19]}, ID_INIT);
      check("example csum", {rx[24], rx[25]}, ip_csum(16'h0020, ID_INIT, 32'hC0A8_010A, 32'hC0A8_0114));
      check("example udp_len", {rx[38], rx[39]}, 16'h000C);
    end else begin
      check("example header present", rx.size(), 42);
    end

    for (int v = 0; v < 10; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].n_in, vecs[v].stall,
                vecs[v].exp_len, vecs[v].exp_err, 1'b0);

    // Oversized request: one error pulse, no ack, no output.
    u_if.udp_length_in = 16'd1473;
    u_if.tx_req_in     = 1'b1;
    errs = 0; acks = 0; valids = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (u_if.tx_err_out) errs++;
      if (u_if.tx_ack_out) acks++;
      if (u_if.axis_tvalid_out) valids++;
      @(posedge clk);
      #1;
    end
    u_if.tx_req_in = 1'b0;
    check("reject err pulses", errs, 1);
    check("reject acks", acks, 0);
    check("reject output beats", valids, 0);

    // Reset while byte 20 of a frame is on the bus.
    u_if.udp_length_in     = 16'd100;
    u_if.tx_req_in         = 1'b1;
    u_if.udpdata_tvalid_in = 1'b1;
    u_if.udpdata_tdata_in  = 8'h5A;
    u_if.udpdata_tlast_in  = 1'b0;
    u_if.axis_tready_in    = 1'b1;
    beats = 0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (u_if.tx_ack_out) u_if.tx_req_in = 1'b0;
      if (u_if.axis_tvalid_out && beats == 19) begin
        reached = 1'b1;
        #1 reset = 1'b0;
        break;
      end
      if (u_if.axis_tvalid_out && u_if.axis_tready_in) beats++;
    end
    check("reset reached byte 20", reached, 1'b1);
    u_if.tx_req_in = 1'b0;
    u_if.udpdata_tvalid_in = 1'b0;
    @(posedge clk);
    #1;
    check("midframe reset tvalid", u_if.axis_tvalid_out, 1'b0);
    check("midframe reset tlast", u_if.axis_tlast_out, 1'b0);
    check("midframe reset busy", u_if.busy_out, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_id = ID_INIT;
    @(posedge clk);
    #1;
    run_frame("post_reset", 10, 10, 1'b0, PAD_EN ? 60 : 52, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
